// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, write-enable codes and FSM states.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_B    = 2'd0,
        SIZE_H    = 2'd1,
        SIZE_W    = 2'd2,
        SIZE_RSVD = 2'd3
    } size_e;

    localparam logic [1:0] WR_NONE = 2'd0;
    localparam logic [1:0] WR_B    = 2'd1;
    localparam logic [1:0] WR_H    = 2'd2;
    localparam logic [1:0] WR_W    = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        LOAD_DATA = 2'd2,
        RESP      = 2'd3
    } state_e;

    function automatic logic [2:0] size_nbytes(input size_e size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            SIZE_W:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [1:0] size_wr_code(input size_e size);
        case (size)
            SIZE_B:  return WR_B;
            SIZE_H:  return WR_H;
            SIZE_W:  return WR_W;
            default: return WR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational sign/zero extension of the raw memory read word by access size.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] data,
    input  size_e       size,
    input  logic        is_unsigned,
    output logic [31:0] ext
);

    // Select the low byte/half and extend it; words pass straight through.
    always_comb begin
        ext = 32'd0;
        case (size)
            SIZE_B: begin
                if (is_unsigned) begin
                    ext = {24'd0, data[7:0]};
                end else begin
                    ext = {{24{data[7]}}, data[7:0]};
                end
            end
            SIZE_H: begin
                if (is_unsigned) begin
                    ext = {16'd0, data[15:0]};
                end else begin
                    ext = {{16{data[15]}}, data[15:0]};
                end
            end
            SIZE_W:  ext = data;
            default: ext = data;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit in front of a byte-addressed data memory.
// Optional build macro LSU_MISALIGN_TRAP_EN rejects misaligned half/word accesses.
module lsu
    import lsu_pkg::*;
#(
    parameter int MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_rd_addr,
    input  logic [31:0] mem_rd_data,
    output logic [1:0]  mem_wr_en,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data
);

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_SIZE);

    state_e      state_r;
    state_e      state_s;
    logic        we_r;
    size_e       size_r;
    logic        uns_r;
    logic        resp_valid_r;
    logic [31:0] resp_rdata_r;
    logic        resp_err_r;
    logic [31:0] mem_rd_addr_r;
    logic [1:0]  mem_wr_en_r;
    logic [31:0] mem_wr_addr_r;
    logic [31:0] mem_wr_data_r;

    size_e       req_size_s;
    logic [32:0] end_addr_s;
    logic        err_s;
    logic        accept_s;
    logic [31:0] ext_s;

    assign req_ready   = (state_r == IDLE) && !rst;
    assign accept_s    = req_valid && req_ready;
    assign resp_valid  = resp_valid_r;
    assign resp_rdata  = resp_rdata_r;
    assign resp_err    = resp_err_r;
    assign mem_rd_addr = mem_rd_addr_r;
    assign mem_wr_en   = mem_wr_en_r;
    assign mem_wr_addr = mem_wr_addr_r;
    assign mem_wr_data = mem_wr_data_r;

    // Request legality: the end address is formed 33 bits wide so it cannot wrap.
    always_comb begin
        req_size_s = size_e'(req_size);
        end_addr_s = {1'b0, req_addr} + {30'd0, size_nbytes(req_size_s)};
        err_s      = 1'b0;
        if (req_size_s == SIZE_RSVD) begin
            err_s = 1'b1;
        end else if (end_addr_s > MEM_LIMIT) begin
            err_s = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        end else if (((req_size_s == SIZE_H) && (req_addr[0] != 1'b0)) ||
                     ((req_size_s == SIZE_W) && (req_addr[1:0] != 2'b00))) begin
            err_s = 1'b1;
`endif
        end else begin
            err_s = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = err_s ? RESP : ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (we_r) begin
                    state_s = RESP;
                end else begin
                    state_s = LOAD_DATA;
                end
            end
            LOAD_DATA: state_s = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request capture, memory port drive and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_r          <= 1'b0;
            size_r        <= SIZE_B;
            uns_r         <= 1'b0;
            resp_valid_r  <= 1'b0;
            resp_rdata_r  <= 32'd0;
            resp_err_r    <= 1'b0;
            mem_rd_addr_r <= 32'd0;
            mem_wr_en_r   <= WR_NONE;
            mem_wr_addr_r <= 32'd0;
            mem_wr_data_r <= 32'd0;
        end else begin
            // Write strobe is a single-cycle pulse covering only ACCESS.
            mem_wr_en_r  <= WR_NONE;
            resp_valid_r <= (state_s == RESP);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        we_r          <= req_we;
                        size_r        <= req_size_s;
                        uns_r         <= req_unsigned;
                        mem_rd_addr_r <= req_addr;
                        mem_wr_addr_r <= req_addr;
                        mem_wr_data_r <= req_wdata;
                        resp_rdata_r  <= 32'd0;
                        resp_err_r    <= err_s;
                        if (req_we && !err_s) begin
                            mem_wr_en_r <= size_wr_code(req_size_s);
                        end
                    end
                end
                LOAD_DATA: resp_rdata_r <= ext_s;
                default: ;
            endcase
        end
    end

    lsu_load_ext u_load_ext (
        .data        (mem_rd_data),
        .size        (size_r),
        .is_unsigned (uns_r),
        .ext         (ext_s)
    );

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: directed cases then random traffic against a byte-array reference model.
module tb_lsu;

    localparam int MEM_SIZE = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic [1:0]  mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;

    lsu #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
        int          lat;
    } exp_t;

    typedef struct {
        logic [1:0]  en;
        logic [31:0] addr;
        logic [31:0] data;
    } wexp_t;

    exp_t        q[$];
    wexp_t       wq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    bit          hs_prev = 1'b0;
    bit          seen_valid = 1'b0;
    int          hold_cnt = 0;
    bit          rand_ready = 1'b0;
    bit [7:0]    ref_mem [MEM_SIZE];

    // Attached memory: registered read port, byte-granular sized write port.
    logic [7:0]  mem [MEM_SIZE];
    bit          mem_inited = 1'b0;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) ^ (i >> 3));
    endfunction

    function automatic int nbytes_of(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] mem_rd4(input logic [31:0] a);
        logic [31:0] v;
        v = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if ({32'd0, a} + 64'(k) < 64'(MEM_SIZE)) begin
                v = v | (32'(mem[int'(a) + k]) << (8 * k));
            end
        end
        return v;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_inited) begin
            for (int i = 0; i < MEM_SIZE; i++) mem[i] <= init_byte(i);
            mem_inited <= 1'b1;
        end else if (mem_wr_en != 2'd0) begin
            for (int k = 0; k < nbytes_of(mem_wr_en - 2'd1); k++) begin
                if ({32'd0, mem_wr_addr} + 64'(k) < 64'(MEM_SIZE)) begin
                    mem[int'(mem_wr_addr) + k] <= 8'(mem_wr_data >> (8 * k));
                end
            end
        end
        mem_rd_data <= mem_rd4(mem_rd_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: decide legality and the response from plain byte arithmetic.
    task automatic model_push(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        wexp_t       w;
        int          nb;
        longint      v;
        bit          err;
        nb  = nbytes_of(sz);
        err = (sz == 2'd3) || ({32'd0, a} + 64'(nb) > 64'(MEM_SIZE));
`ifdef LSU_MISALIGN_TRAP_EN
        if (sz == 2'd1 && (a % 2) != 0) err = 1'b1;
        if (sz == 2'd2 && (a % 4) != 0) err = 1'b1;
`endif
        e.acc_cyc = cyc + 1;
        e.err     = err;
        e.rdata   = 32'd0;
        if (err) begin
            e.lat = 0;
        end else if (we) begin
            e.lat = 1;
            for (int k = 0; k < nb; k++) ref_mem[int'(a) + k] = 8'(wd >> (8 * k));
            w.en   = sz + 2'd1;
            w.addr = a;
            w.data = wd;
            wq.push_back(w);
        end else begin
            e.lat = 2;
            v = 0;
            for (int k = 0; k < nb; k++) v = v + (longint'(ref_mem[int'(a) + k]) << (8 * k));
            if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
            e.rdata = 32'(v);
        end
        q.push_back(e);
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd);
        bit got;
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout: req_ready never rose for addr 0x%08h", a);
            req_valid = 1'b0;
        end else begin
            model_push(we, sz, uns, a, wd);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            acc_cnt++;
        end
    endtask

    // Response-side backpressure: forced low while hold_cnt runs, else high or random.
    initial begin
        resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold_cnt > 0) begin
                resp_ready = 1'b0;
                hold_cnt--;
            end else begin
                resp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // Monitor: checks ready, write-port activity and every response cycle against the queues.
    initial begin
        exp_t  e;
        wexp_t w;
        forever begin
            @(negedge clk);
            if (hs_prev) begin
                done_cnt++;
                hs_prev = 1'b0;
            end
            chk("req_ready", 32'(req_ready), 32'((acc_cnt == done_cnt) && !rst));
            if (mem_wr_en != 2'd0) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 32'(mem_wr_en), 32'd0);
                end else begin
                    w = wq.pop_front();
                    chk("wr_en", 32'(mem_wr_en), 32'(w.en));
                    chk("wr_addr", mem_wr_addr, w.addr);
                    chk("wr_data", mem_wr_data, w.data);
                end
            end
            if (resp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", 32'(resp_valid), 32'd0);
                end else begin
                    e = q[0];
                    if (!seen_valid) begin
                        seen_valid = 1'b1;
                        chk("resp_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                    end
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", 32'(resp_err), 32'(e.err));
                    if (resp_ready) begin
                        void'(q.pop_front());
                        chk("write_done", 32'(wq.size()), 32'd0);
                        seen_valid = 1'b0;
                        hs_prev = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = init_byte(i);
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_rd_addr", mem_rd_addr, 32'd0);
        chk("rst_wr_addr", mem_wr_addr, 32'd0);
        chk("rst_wr_data", mem_wr_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        do_req(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'(MEM_SIZE - 2), 32'h0);
        do_req(1'b1, 2'd2, 1'b0, 32'(MEM_SIZE - 2), 32'h12345678);
        do_req(1'b0, 2'd3, 1'b0, 32'h20, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFF, 32'h0);
        do_req(1'b0, 2'd0, 1'b1, 32'(MEM_SIZE - 1), 32'h0);
        hold_cnt = 8;
        do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        do_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
        do_req(1'b0, 2'd1, 1'b1, 32'h11, 32'h0);

        // Reset while the load sits in LOAD_DATA: response dropped.
        do_req(1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        wq.delete();
        seen_valid = 1'b0;
        hs_prev = 1'b0;
        done_cnt = acc_cnt;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            sz = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) begin
                a = $urandom;
            end else begin
                a = 32'($urandom_range(0, MEM_SIZE + 3));
            end
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
